dmem_wbuf: RTL and testbench
============================

Name: dmem_wbuf

Overview:
- Posted-write buffer placed between one CMP node's data-memory port and its dmem instance. One instance per node.
- Node writes retire into a DEPTH-entry in-order FIFO. The FIFO drains to memory whenever the memory port is free and ready.
- Node reads go straight to memory, with store-to-load forwarding from pending FIFO entries.
- A flush handshake drains the buffer completely before dmem contents are dumped.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- AW, 8, memory address width; compares use node_addr[24:31]
- DW, 64, data width

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- node_memEn  in  1  node memory access request
- node_memWrEn  in  1  1 = write, 0 = read (qualified by node_memEn)
- node_addr  in  [0:31]  node address; only [24:31] used
- node_d_out  in  [0:63]  node write data
- node_d_in  out  [0:63]  read data to node
- node_stall  out  1  access not accepted this cycle; node must hold its request
- flush  in  1  drain request (level)
- flush_done  out  1  FIFO empty while flush held
- occupancy  out  [0:2]  valid entry count, 0..DEPTH
- mem_ready  in  1  memory can accept an access this cycle
- mem_memEn  out  1  dmem enable
- mem_memWrEn  out  1  dmem write enable
- mem_memAddr  out  [0:7]  dmem address
- mem_dataIn  out  [0:63]  dmem write data
- mem_dataOut  in  [0:63]  dmem read data, valid the cycle after an issued read

Behaviour:
- Reset (asynchronous, reset=0):
  - All entries invalidated; head, tail and count zeroed.
  - fwd_hit_q=0, fwd_data_q=0, flush_done=0.
  - Because mem_* are combinational from state, all mem_* outputs are 0, node_stall=0, occupancy=0.
  - Pending writes are discarded; reset mid-drain loses them by design.
- Each cycle, in priority order:
  - 1) flush=1: node_stall = node_memEn; no node access is accepted.
  - 2) Node read (node_memEn=1, node_memWrEn=0):
    - mem_ready=1: issue mem_memEn=1, mem_memWrEn=0, mem_memAddr=node_addr[24:31], mem_dataIn=0; node_stall=0.
    - mem_ready=0: node_stall=1; nothing issued.
  - 3) Otherwise, if count>0 and mem_ready=1: drain head entry with mem_memEn=1, mem_memWrEn=1, head addr/data; pop at posedge.
  - 4) Otherwise mem_* all 0.
- Node write (node_memEn=1, node_memWrEn=1, flush=0):
  - count<DEPTH: push {node_addr[24:31], node_d_out} at tail; node_stall=0.
  - count==DEPTH: node_stall=1, no push, even if a drain occurs the same cycle. The write is accepted the next cycle.
- A push and a drain in the same cycle leave count unchanged; head and tail both advance, with mod-DEPTH wrap-around.
- Forwarding: on an issued read, compare mem_memAddr against all valid entries.
  - The youngest matching entry wins (most recent push).
  - Register fwd_hit_q and fwd_data_q at posedge.
  - node_d_in = fwd_hit_q ? fwd_data_q : mem_dataOut.
  - Read latency to node is 1 cycle, identical with or without a hit.
  - No entry is popped during a read cycle, so the match set is stable.
- Duplicate addresses are not coalesced; entries drain in push order.
- flush_done is registered: set at the posedge where flush=1 and count==0 (including count reaching 0 that edge); cleared whenever flush=0.
- occupancy = count, exactly.

Test Plan:
- Reset: assert reset=0 mid-operation with occupancy=3 → all mem_* 0, node_stall 0, occupancy 0, flush_done 0. After release, no drain writes appear.
- Single write: mem_ready=1, write node_addr=32'h00000005, data 64'h00000000000000AA → occupancy 1 after the push edge. Next cycle mem_memEn=1, mem_memWrEn=1, mem_memAddr=8'h05, mem_dataIn=64'h..AA; occupancy then 0.
- Full/stall: mem_ready=0, push 4 writes to addrs 1–4 → occupancy 4. A 5th write to addr 5 gets node_stall=1. Raise mem_ready → drains addrs 1,2,3,4 on consecutive cycles; addr 5 is accepted one cycle after the first drain.
- Forwarding, youngest wins: mem_ready=0, write 8'h10←64'hA, then 8'h10←64'hB. Set mem_ready=1 and read 8'h10 while mem_dataOut=64'hFFFF → next-cycle node_d_in=64'hB.
- Forwarding miss: same state, read 8'h11 with mem_dataOut=64'h1234 → node_d_in=64'h1234.
- Flush: occupancy 3, flush=1, node requests a read → node_stall=1 throughout. Three drain cycles, then flush_done=1 on the edge where count hits 0; flush_done drops the cycle after flush falls.

Source files
------------

// File: rtl/dmem_wbuf.sv
// Posted-write buffer between a node's data-memory port and its dmem.
// Writes queue in an in-order FIFO that drains when the port is idle; reads bypass with store-to-load forwarding.
module dmem_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  node_memEn,
  input  logic                  node_memWrEn,
  input  logic [0:31]           node_addr,
  input  logic [0:DW-1]         node_d_out,
  output logic [0:DW-1]         node_d_in,
  output logic                  node_stall,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [0:$clog2(DEPTH)] occupancy,
  input  logic                  mem_ready,
  output logic                  mem_memEn,
  output logic                  mem_memWrEn,
  output logic [0:AW-1]         mem_memAddr,
  output logic [0:DW-1]         mem_dataIn,
  input  logic [0:DW-1]         mem_dataOut
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [0:AW-1] addr_q [DEPTH];
  logic [0:DW-1] data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_nxt;
  logic          fwd_hit_q;
  logic [0:DW-1] fwd_data_q;

  logic [0:AW-1] node_a;
  logic          rd_req, wr_req, full, issue_rd, drain, push;
  logic          fwd_hit;
  logic [0:DW-1] fwd_data;
  logic [PW-1:0] idx;

  assign node_a    = node_addr[32-AW:31];
  assign occupancy = count_q;
  assign node_d_in = fwd_hit_q ? fwd_data_q : mem_dataOut;

  always_comb begin
    rd_req      = node_memEn & ~node_memWrEn & ~flush;
    wr_req      = node_memEn &  node_memWrEn & ~flush;
    full        = (count_q == CW'(DEPTH));
    issue_rd    = rd_req & mem_ready;
    drain       = ~rd_req & mem_ready & (count_q != '0);
    // A full buffer stalls the write even if a drain frees a slot this cycle.
    push        = wr_req & ~full;
    node_stall  = flush ? node_memEn : ((rd_req & ~mem_ready) | (wr_req & full));
    count_nxt   = count_q + CW'(push) - CW'(drain);
    mem_memEn   = 1'b0;
    mem_memWrEn = 1'b0;
    mem_memAddr = '0;
    mem_dataIn  = '0;
    if (issue_rd) begin
      mem_memEn   = 1'b1;
      mem_memAddr = node_a;
    end else if (drain) begin
      mem_memEn   = 1'b1;
      mem_memWrEn = 1'b1;
      mem_memAddr = addr_q[head_q];
      mem_dataIn  = data_q[head_q];
    end
  end

  // Walk oldest to youngest so the last match (most recent push) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == node_a)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      flush_done <= 1'b0;
    end else begin
      if (push) begin
        addr_q[tail_q] <= node_a;
        data_q[tail_q] <= node_d_out;
        tail_q         <= tail_q + 1'b1;
      end
      if (drain) head_q <= head_q + 1'b1;
      count_q    <= count_nxt;
      fwd_hit_q  <= issue_rd & fwd_hit;
      if (issue_rd) fwd_data_q <= fwd_data;
      flush_done <= flush & (count_nxt == '0);
    end
  end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Self-checking bench for dmem_wbuf: directed scenarios then random traffic,
// checked against a queue-based model of the buffer.
module tb_dmem_wbuf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        node_memEn, node_memWrEn, flush, mem_ready;
  logic [31:0] node_addr;
  logic [63:0] node_d_out, node_d_in, mem_dataIn, mem_dataOut;
  logic        node_stall, flush_done, mem_memEn, mem_memWrEn;
  logic [2:0]  occupancy;
  logic [7:0]  mem_memAddr;

  dmem_wbuf #(.DEPTH(DEPTH), .AW(8), .DW(64)) dut (
    .clk(clk), .reset(reset),
    .node_memEn(node_memEn), .node_memWrEn(node_memWrEn),
    .node_addr(node_addr), .node_d_out(node_d_out), .node_d_in(node_d_in),
    .node_stall(node_stall), .flush(flush), .flush_done(flush_done),
    .occupancy(occupancy), .mem_ready(mem_ready),
    .mem_memEn(mem_memEn), .mem_memWrEn(mem_memWrEn),
    .mem_memAddr(mem_memAddr), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_rd = 1'b0;
  logic        prev_hit = 1'b0;
  logic [63:0] prev_data = '0;
  logic        exp_fd = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: drive after negedge, check, advance the model at posedge.
  task automatic cycle(input logic en, input logic wr, input logic [7:0] a,
                       input logic [63:0] d, input logic fl, input logic rdy,
                       input logic [63:0] dout);
    logic rd, wq, e_stall, e_en, e_wr, do_push, do_pop, hit;
    logic [7:0]  e_addr;
    logic [63:0] e_din, hdata;
    @(negedge clk);
    node_memEn = en; node_memWrEn = wr; node_addr = {24'h0, a};
    node_d_out = d; flush = fl; mem_ready = rdy; mem_dataOut = dout;
    #1;
    rd = en && !wr && !fl;
    wq = en && wr && !fl;
    if (fl)      e_stall = en;
    else if (rd) e_stall = !rdy;
    else if (wq) e_stall = (q.size() == DEPTH);
    else         e_stall = 1'b0;
    e_en = 0; e_wr = 0; e_addr = 0; e_din = 0; do_pop = 0; hit = 0; hdata = 0;
    if (rd && rdy) begin
      e_en = 1; e_addr = a;
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].a == a) begin hit = 1; hdata = q[i].d; break; end
    end else if (!rd && rdy && q.size() > 0) begin
      e_en = 1; e_wr = 1; e_addr = q[0].a; e_din = q[0].d; do_pop = 1;
    end
    do_push = wq && (q.size() < DEPTH);
    chk("node_stall", node_stall, e_stall);
    chk("mem_memEn", mem_memEn, e_en);
    chk("mem_memWrEn", mem_memWrEn, e_wr);
    chk("mem_memAddr", mem_memAddr, e_addr);
    chk("mem_dataIn", mem_dataIn, e_din);
    chk("occupancy", occupancy, q.size());
    chk("flush_done", flush_done, exp_fd);
    if (prev_rd) chk("node_d_in", node_d_in, prev_hit ? prev_data : dout);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{a: a, d: d});
    prev_rd   = rd && rdy;
    prev_hit  = hit;
    prev_data = hdata;
    exp_fd    = fl && (q.size() == 0);
  endtask

  task automatic idle(input logic rdy);
    cycle(0, 0, 8'h00, 64'h0, 0, rdy, {$urandom, $urandom});
  endtask

  task automatic check_reset_outputs();
    chk("rst mem_memEn", mem_memEn, 1'b0);
    chk("rst mem_memWrEn", mem_memWrEn, 1'b0);
    chk("rst mem_memAddr", mem_memAddr, 8'h00);
    chk("rst mem_dataIn", mem_dataIn, 64'h0);
    chk("rst node_stall", node_stall, 1'b0);
    chk("rst occupancy", occupancy, 3'd0);
    chk("rst flush_done", flush_done, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    node_memEn = 0; node_memWrEn = 0; flush = 0; mem_ready = 1;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    check_reset_outputs();
    q.delete();
    prev_rd = 0; prev_hit = 0; exp_fd = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; node_memEn = 0; node_memWrEn = 0; node_addr = '0;
    node_d_out = '0; flush = 0; mem_ready = 0; mem_dataOut = '0;
    apply_reset();

    // Single write then drain.
    cycle(1, 1, 8'h05, 64'hAA, 0, 1, 64'h0);
    idle(1);
    idle(1);

    // Fill, stall the fifth write, then drain while the fifth is retried.
    for (int i = 1; i <= 4; i++) cycle(1, 1, 8'(i), 64'h100 + 64'(i), 0, 0, 64'h0);
    cycle(1, 1, 8'h05, 64'h105, 0, 0, 64'h0);
    cycle(1, 1, 8'h05, 64'h105, 0, 1, 64'h0);
    cycle(1, 1, 8'h05, 64'h105, 0, 1, 64'h0);
    for (int i = 0; i < 5; i++) idle(1);

    // Forwarding: youngest wins, then a miss.
    cycle(1, 1, 8'h10, 64'hA, 0, 0, 64'h0);
    cycle(1, 1, 8'h10, 64'hB, 0, 0, 64'h0);
    cycle(1, 0, 8'h10, 64'h0, 0, 1, 64'hFFFF);
    cycle(1, 0, 8'h11, 64'h0, 0, 1, 64'hFFFF);
    idle(0);
    cycle(0, 0, 8'h00, 64'h0, 0, 0, 64'h1234);
    for (int i = 0; i < 3; i++) idle(1);

    // Flush with three pending writes and a read held by the node.
    for (int i = 0; i < 3; i++) cycle(1, 1, 8'h20 + 8'(i), 64'h200 + 64'(i), 0, 0, 64'h0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'h20, 64'h0, 1, 1, 64'h0);
    idle(1);
    idle(1);

    // Reset mid-operation with three pending writes; nothing may drain afterwards.
    for (int i = 0; i < 3; i++) cycle(1, 1, 8'h30 + 8'(i), 64'h300 + 64'(i), 0, 0, 64'h0);
    apply_reset();
    for (int i = 0; i < 3; i++) idle(1);

    // Random traffic on a small address set to exercise forwarding and wrap-around.
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 7)), {$urandom, $urandom},
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
            {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
